// File: rtl/match_controller_if.sv
// Signal bundle between the match controller and its neighbours
// (ball controller inputs, scoreboard/overlay outputs).
interface match_controller_if;
  logic       i_btn_start;
  logic       i_miss_left;
  logic       i_miss_right;
  logic       o_ball_hold;
  logic       o_serve_dir;
  logic [3:0] o_score_left;
  logic [3:0] o_score_right;
  logic [1:0] o_game_state;
  logic       o_winner;

  modport master (
    output i_btn_start, i_miss_left, i_miss_right,
    input  o_ball_hold, o_serve_dir, o_score_left, o_score_right, o_game_state, o_winner
  );

  modport slave (
    input  i_btn_start, i_miss_left, i_miss_right,
    output o_ball_hold, o_serve_dir, o_score_left, o_score_right, o_game_state, o_winner
  );
endinterface

// File: rtl/match_controller.sv
// Match-level FSM: scoring, serve hold/release and end-of-match detection.
// Optional MATCH_AUTO_RESTART_EN returns GAME_OVER to IDLE after RESTART_DELAY cycles.
module match_controller #(
  parameter int WIN_SCORE     = 11,
  parameter int SERVE_DELAY   = 65_000_000,
  parameter int RESTART_DELAY = 325_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  match_controller_if.slave bus
);

  localparam int MAX_DELAY = (SERVE_DELAY > RESTART_DELAY) ? SERVE_DELAY : RESTART_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
`ifdef MATCH_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0] RESTART_LOAD = CNT_W'(RESTART_DELAY - 1);
`endif
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_SERVE     = 2'b01,
    S_PLAY      = 2'b10,
    S_GAME_OVER = 2'b11
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_score_left;
  logic [3:0]       r_score_right;
  logic             r_serve_dir;
  logic             r_winner;
  logic             r_ball_hold;
  logic             r_start_d;
  logic             r_miss_left_d;
  logic             r_miss_right_d;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_count_next;
  logic [3:0]       w_score_left_next;
  logic [3:0]       w_score_right_next;
  logic             w_serve_dir_next;
  logic             w_winner_next;
  logic             w_start_ev;
  logic             w_miss_left_ev;
  logic             w_miss_right_ev;

  assign w_start_ev      = bus.i_btn_start  & ~r_start_d;
  assign w_miss_left_ev  = bus.i_miss_left  & ~r_miss_left_d;
  assign w_miss_right_ev = bus.i_miss_right & ~r_miss_right_d;

  always_comb begin
    w_state_next       = r_state;
    w_count_next       = r_count;
    w_score_left_next  = r_score_left;
    w_score_right_next = r_score_right;
    w_serve_dir_next   = r_serve_dir;
    w_winner_next      = r_winner;

    case (r_state)
      S_IDLE: begin
        if (w_start_ev) begin
          w_state_next = S_SERVE;
          w_count_next = SERVE_LOAD;
        end
      end

      S_SERVE: begin
        if (r_count == '0) begin
          w_state_next = S_PLAY;
        end else begin
          w_count_next = r_count - 1'b1;
        end
      end

      // Simultaneous misses cancel out and simply re-serve.
      S_PLAY: begin
        if (w_miss_left_ev && w_miss_right_ev) begin
          w_state_next = S_SERVE;
          w_count_next = SERVE_LOAD;
        end else if (w_miss_left_ev) begin
          w_score_right_next = r_score_right + 4'd1;
          w_serve_dir_next   = 1'b0;
          if (w_score_right_next == WIN) begin
            w_state_next  = S_GAME_OVER;
            w_winner_next = 1'b1;
`ifdef MATCH_AUTO_RESTART_EN
            w_count_next  = RESTART_LOAD;
`endif
          end else begin
            w_state_next = S_SERVE;
            w_count_next = SERVE_LOAD;
          end
        end else if (w_miss_right_ev) begin
          w_score_left_next = r_score_left + 4'd1;
          w_serve_dir_next  = 1'b1;
          if (w_score_left_next == WIN) begin
            w_state_next  = S_GAME_OVER;
            w_winner_next = 1'b0;
`ifdef MATCH_AUTO_RESTART_EN
            w_count_next  = RESTART_LOAD;
`endif
          end else begin
            w_state_next = S_SERVE;
            w_count_next = SERVE_LOAD;
          end
        end
      end

      S_GAME_OVER: begin
        if (w_start_ev) begin
          w_state_next       = S_SERVE;
          w_count_next       = SERVE_LOAD;
          w_score_left_next  = 4'd0;
          w_score_right_next = 4'd0;
          w_serve_dir_next   = 1'b1;
        end
`ifdef MATCH_AUTO_RESTART_EN
        else if (r_count == '0) begin
          w_state_next       = S_IDLE;
          w_score_left_next  = 4'd0;
          w_score_right_next = 4'd0;
          w_serve_dir_next   = 1'b1;
        end else begin
          w_count_next = r_count - 1'b1;
        end
`endif
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ball_hold is derived from the next state so it stays a pure register output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_score_left   <= 4'd0;
      r_score_right  <= 4'd0;
      r_serve_dir    <= 1'b1;
      r_winner       <= 1'b0;
      r_ball_hold    <= 1'b1;
      r_start_d      <= 1'b0;
      r_miss_left_d  <= 1'b0;
      r_miss_right_d <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_score_left   <= w_score_left_next;
      r_score_right  <= w_score_right_next;
      r_serve_dir    <= w_serve_dir_next;
      r_winner       <= w_winner_next;
      r_ball_hold    <= (w_state_next != S_PLAY);
      r_start_d      <= bus.i_btn_start;
      r_miss_left_d  <= bus.i_miss_left;
      r_miss_right_d <= bus.i_miss_right;
    end
  end

  assign bus.o_ball_hold   = r_ball_hold;
  assign bus.o_serve_dir   = r_serve_dir;
  assign bus.o_score_left  = r_score_left;
  assign bus.o_score_right = r_score_right;
  assign bus.o_game_state  = r_state;
  assign bus.o_winner      = r_winner;

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Match-level FSM directly downstream of the ball controller; consumes its per-side miss flags.
- Keeps both players' scores, decides when the ball is held at centre or released, and detects the end of the match.
- Its ball_hold output drives the ball controller's reset/serve input.
- Its score and state outputs feed the scoreboard/overlay renderer.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..15.
SERVE_DELAY, 65_000_000, cycles the ball is held at centre before each serve; must be >= 1.
RESTART_DELAY, 325_000_000, cycles in GAME_OVER before auto-return to IDLE; used only with the optional feature.

Ports:
clk  input  1  system clock (65 MHz pixel clock domain)
rst  input  1  asynchronous, active-low reset (0 = reset)
btn_start  input  1  start/restart request, already synchronised and debounced, level
miss_left  input  1  ball behind left pad, level, may stay high for many cycles
miss_right  input  1  ball behind right pad, level
ball_hold  output  1  1 = ball controller held at centre, 0 = ball moving
serve_dir  output  1  0 = next serve travels left, 1 = travels right
score_left  output  4  left player score, binary
score_right  output  4  right player score, binary
game_state  output  2  00 IDLE, 01 SERVE, 10 PLAY, 11 GAME_OVER
winner  output  1  0 = left, 1 = right; meaningful only in GAME_OVER

Behaviour:
- Reset (async assert, sync release), all registered:
  - state IDLE, scores 0, ball_hold 1, serve_dir 1, winner 0.
  - delay counter 0; edge-detect flops 0.
- Edge detection:
  - miss_left, miss_right and btn_start are registered every cycle.
  - An event = input high while its registered copy is low (rising edge).
  - Only events are acted on; a held level never produces a second point or restart.
- IDLE: ball_hold=1. On start event -> SERVE, delay counter loaded with SERVE_DELAY-1.
- SERVE:
  - ball_hold=1; counter decrements each cycle.
  - When counter==0 -> PLAY, so SERVE lasts exactly SERVE_DELAY cycles.
  - Miss and start events are ignored.
- PLAY:
  - ball_hold=0.
  - miss_left event alone -> score_right+1, serve_dir=0 (toward the player who conceded).
  - miss_right event alone -> score_left+1, serve_dir=1.
  - Score, serve_dir and state update on the same edge, 1 cycle after the event is detected.
  - Next state: GAME_OVER if the incremented score equals WIN_SCORE, else SERVE (counter reloaded).
  - Entering GAME_OVER sets winner to the scoring side.
  - Both miss events in the same cycle: no score change, serve_dir unchanged, -> SERVE.
  - Start events are ignored.
- GAME_OVER:
  - ball_hold=1; scores frozen; miss events ignored.
  - Start event -> both scores cleared, winner kept, serve_dir=1, -> SERVE with counter loaded.
- Width rules:
  - Scores never exceed WIN_SCORE and never wrap.
  - Increments happen only in PLAY, and PLAY is never entered with either score at WIN_SCORE.
  - Delay counter width is $clog2 of max(SERVE_DELAY, RESTART_DELAY)+1.
- Reset mid-operation: any state returns to IDLE immediately; scores cleared; no pending event survives.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: MATCH_AUTO_RESTART_EN.
- Defined:
  - Entering GAME_OVER loads the counter with RESTART_DELAY-1.
  - At counter==0 -> IDLE, scores cleared, winner kept, serve_dir=1.
  - A start event before expiry still restarts immediately (-> SERVE as above) and takes priority over expiry in the same cycle.
- Undefined: GAME_OVER is left only by a start event or reset; RESTART_DELAY is unused.

Test Plan:
All tests use WIN_SCORE=3, SERVE_DELAY=4, RESTART_DELAY=8.
1. Reset then btn_start pulse -> game_state 01 for exactly 4 cycles with ball_hold=1, then 10 with ball_hold=0; scores 0/0.
2. In PLAY, miss_left held high 20 cycles -> score_right 0->1 once, serve_dir=0, state SERVE, ball_hold=1; no further increments.
3. Three separate miss_right pulses, each after its serve -> score_left 3, state 11, winner=0; a 4th miss_right pulse leaves the score at 3.
4. In PLAY, miss_left and miss_right rise in the same cycle -> scores unchanged, state SERVE, serve_dir unchanged; a miss pulse during SERVE is ignored.
5. In GAME_OVER, btn_start pulse -> scores 0/0, state SERVE, serve_dir=1. Separately, rst low in PLAY at score 2/1 -> immediately IDLE, 0/0, ball_hold=1.
6. With MATCH_AUTO_RESTART_EN, GAME_OVER and no start -> IDLE after 8 cycles with scores cleared. Start on the expiry cycle -> SERVE, not IDLE.
